// File: rtl/bus_dual_sender_if.sv
// Handshake bundle for bus_dual_sender: payload input plus the two redundant output channels.
// Latency: none, wires only.
// Backpressure: in_ready toward the payload source; a_ready/b_ready from each channel's consumer.
// Ports: in_data/in_valid/in_ready (payload), a_*/b_* (channel word, valid, ready, sof, eof),
//        skew_err (timeout pulse), frames_sent (completed-frame counter).
interface bus_dual_sender_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;
    logic              a_sof;
    logic              a_eof;

    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
    logic              b_sof;
    logic              b_eof;

    logic              skew_err;
    logic [15:0]       frames_sent;

    // master: the sender itself
    modport master (
        input  in_data, in_valid, a_ready, b_ready,
        output in_ready,
        output a_data, a_valid, a_sof, a_eof,
        output b_data, b_valid, b_sof, b_eof,
        output skew_err, frames_sent
    );

    // slave: payload source plus the two channel consumers
    modport slave (
        output in_data, in_valid, a_ready, b_ready,
        input  in_ready,
        input  a_data, a_valid, a_sof, a_eof,
        input  b_data, b_valid, b_sof, b_eof,
        input  skew_err, frames_sent
    );
endinterface

// File: rtl/bus_dual_sender.sv
// Buffers payload words and sends HDR/SEQ/PAYxFRAME_LEN/CHK frames identically on two redundant channels.
// Latency: frame starts two cycles after its last payload word is written; then one word per cycle.
// Backpressure: per-channel ready; a channel never runs more than one word ahead; in_ready low when FIFO full.
// Ports: clk, rst (synchronous, active-high); bus (master modport) carrying in_*, a_*, b_*, skew_err, frames_sent.
module bus_dual_sender #(
    parameter int         DATA_W    = 8,
    parameter int         DEPTH     = 16,
    parameter int         FRAME_LEN = 4,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         SKEW_MAX  = 15
) (
    input  logic              clk,
    input  logic              rst,
    bus_dual_sender_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SKW = (SKEW_MAX < 1) ? 1 : $clog2(SKEW_MAX + 1);

    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    FLEN_C  = (AW + 1)'(FRAME_LEN);
    localparam logic [7:0]     PLAST_C = 8'(FRAME_LEN - 1);
    localparam logic [SKW-1:0] SKEW_C  = SKW'(SKEW_MAX);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CHK} state_t;

    state_t state, state_nxt;

    // payload FIFO
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    logic              in_ready_q;
    logic              push, pop;

    // frame bookkeeping
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] chk;
    logic [7:0]        pay_cnt;
    logic [15:0]       frames_q;

    // per-channel lockstep
    logic              a_done, b_done;
    logic              a_vld, b_vld;
    logic              a_fire, b_fire;
    logic              advance;
    logic              one_done;
    logic [SKW-1:0]    skew_cnt;
    logic              skew_hit;

    // shared word for both channels
    logic [DATA_W-1:0] word;
    logic              sof, eof;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign push = bus.in_valid && in_ready_q;
    assign pop  = advance && (state == PAY);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // in_ready is registered off the next count so it is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            in_ready_q <= (count_nxt != DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // ------------------------------------------------------------------
    // Channel handshakes. A channel that has already taken the current
    // word drops valid and waits; the word advances once both have it.
    // ------------------------------------------------------------------
    assign a_fire  = a_vld && bus.a_ready;
    assign b_fire  = b_vld && bus.b_ready;
    assign advance = (a_done || a_fire) && (b_done || b_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
        end else if (advance) begin
            a_done <= 1'b0;
            b_done <= 1'b0;
        end else begin
            if (a_fire) a_done <= 1'b1;
            if (b_fire) b_done <= 1'b1;
        end
    end

    // Skew watchdog: only reports, never disturbs the frame in flight.
    assign one_done = a_done ^ b_done;
    assign skew_hit = one_done && !advance && (skew_cnt == SKEW_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            skew_cnt <= '0;
        end else if (advance || !one_done || skew_hit) begin
            skew_cnt <= '0;
        end else begin
            skew_cnt <= skew_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state. A frame only starts once its whole payload is
    // buffered, so PAY can never stall on an empty FIFO.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count >= FLEN_C)                    state_nxt = HDR;
            HDR:  if (advance)                            state_nxt = SEQ;
            SEQ:  if (advance)                            state_nxt = PAY;
            PAY:  if (advance && (pay_cnt == PLAST_C))    state_nxt = CHK;
            CHK:  if (advance)                            state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Word depends only on state and registers, so it holds
    // steady while either channel is still waiting.
    always_comb begin
        word  = '0;
        sof   = 1'b0;
        eof   = 1'b0;
        a_vld = (state != IDLE) && !a_done;
        b_vld = (state != IDLE) && !b_done;
        case (state)
            HDR: begin
                word = DATA_W'(HEADER);
                sof  = 1'b1;
            end
            SEQ: word = seq;
            PAY: word = mem[rd_ptr];
            CHK: begin
                word = chk;
                eof  = 1'b1;
            end
            default: word = '0;
        endcase
    end

    // Frame registers: checksum seeded with seq, folded with each payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= '0;
            chk      <= '0;
            pay_cnt  <= '0;
            frames_q <= '0;
        end else if (advance) begin
            case (state)
                SEQ: begin
                    chk     <= seq;
                    pay_cnt <= '0;
                end
                PAY: begin
                    chk     <= chk ^ word;
                    pay_cnt <= (pay_cnt == PLAST_C) ? 8'd0 : pay_cnt + 8'd1;
                end
                CHK: begin
                    seq      <= seq + 1'b1;
                    frames_q <= frames_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready_q;
    assign bus.a_data      = word;
    assign bus.b_data      = word;
    assign bus.a_sof       = sof;
    assign bus.b_sof       = sof;
    assign bus.a_eof       = eof;
    assign bus.b_eof       = eof;
    assign bus.a_valid     = a_vld;
    assign bus.b_valid     = b_vld;
    assign bus.skew_err    = skew_hit;
    assign bus.frames_sent = frames_q;
endmodule
